adder_result_stage: RTL and testbench
=====================================

// Module: adder_result_stage
// PURPOSE
//  Pipeline stage directly downstream of the 64-bit ripple-carry adder in EX.
//  Captures sum/carry/overflow into a 2-entry skid buffer with valid/ready handshake.
//  Derives NZCV per entry; commits to the architectural flag register on consumption.
//  Decouples adder (multi-gate-delay path) timing from the MEM/WB consumer.
// PARAMETERS
//  WIDTH  64  datapath width of sum; N = sum[WIDTH-1]
// PORTS
//  clk            in   1      single clock, rising edge
//  reset_n        in   1      asynchronous, active-low reset
//  in_valid       in   1      adder result valid this cycle
//  in_ready       out  1      stage can accept (registered, independent of out_ready)
//  in_sum         in   WIDTH  adder sum
//  in_carry       in   1      adder carry_out (C[64])
//  in_overflow    in   1      adder overflow (C[64]^C[63])
//  in_set_flags   in   1      instruction writes flags (ADDS/SUBS)
//  out_valid      out  1      head entry valid
//  out_ready      in   1      consumer accepts head
//  out_sum        out  WIDTH  head entry sum
//  out_set_flags  out  1      head entry set_flags bit
//  flag_n/z/c/v   out  1 ea   architectural NZCV register
//  flags_wr       out  1      1-cycle pulse: flag register written this edge (registered)
// BEHAVIOUR
//  - Storage: 2 entries {sum, n, z, c, v, set_flags}; head/tail pointer + count 0..2.
//  - Entry fields at push: n=in_sum[WIDTH-1], z=(in_sum==0), c=in_carry, v=in_overflow.
//  - push = in_valid & in_ready; pop = out_valid & out_ready.
//  - in_ready = (count != 2); out_valid = (count != 0). Both from registered count.
//  - States EMPTY(0) -> ONE on push; ONE -> FULL on push&!pop; ONE -> EMPTY on pop&!push;
//    ONE stays on push&pop; FULL -> ONE on pop (push impossible, in_ready=0).
//  - Latency: push at edge k -> out_valid=1 with data at k+1 (min 1 cycle).
//  - Order strictly FIFO; head data stable while out_valid & !out_ready.
//  - Pointers wrap modulo 2; in_valid while !in_ready ignored (no overwrite).
//  - Flag commit: at edge where pop & head.set_flags: NZCV <= head.{n,z,c,v}, flags_wr <= 1;
//    else NZCV hold, flags_wr <= 0. Pop with set_flags=0 never modifies flags.
//  - Reset (async assert, any time incl. mid-transfer): count=0, pointers=0,
//    out_valid=0, in_ready=1, out_sum=0, out_set_flags=0, NZCV=0000, flags_wr=0.
//    In-flight entries discarded. Deassertion synchronous to clk.
//  - out_sum/out_set_flags read 0 when empty (storage masked by out_valid).
// CONFIGURATION
//  FLAGS_BYPASS_EN defined: flag_n/z/c/v = (pop & head.set_flags) ? head.{n,z,c,v}
//    : registered NZCV -- branch logic sees committing flags same cycle (comb path).
//  Not defined: flag_* = registered NZCV only; new flags visible cycle after pop.
//  flags_wr and register contents identical in both builds.
// TESTING
//  1 Reset: reset_n=0 mid-stream with count=2 -> out_valid=0, in_ready=1, NZCV=0000 same cycle.
//  2 Single pass: push sum=0, c=1, v=0, set=1, out_ready=1 -> out_valid next cycle,
//    out_sum=0; after pop edge NZCV=0110, flags_wr=1 for one cycle.
//  3 Backpressure: out_ready=0, push 0x1 then 0x8000_0000_0000_0000 -> in_ready=0,
//    third in_valid ignored; release out_ready -> outputs 0x1 then 0x8000..., order kept.
//  4 No-set pop: push sum=0xFFFF_FFFF_FFFF_FFFF, set=0 after NZCV=0110 -> NZCV stays 0110,
//    flags_wr=0.
//  5 Simultaneous push/pop at count=1 for 10 cycles, sums 1..10 -> count stays 1,
//    outputs 1..10 in order, 1-cycle latency each.
//  6 Bypass: pop entry n=1,v=1,set=1 -> with FLAGS_BYPASS_EN flag_n=1,flag_v=1 in pop
//    cycle; without, they change only after the pop edge.

Source files
------------

// File: rtl/adder_result_stage.sv
// Two-entry skid buffer behind the EX adder. It derives NZCV for each entry and commits NZCV to the flag register when a flag-setting entry is popped.
// Optional build macro FLAGS_BYPASS_EN: the committing flags appear on flag_n/z/c/v combinationally during the pop cycle.
module adder_result_stage #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sum,
    input  logic             in_carry,
    input  logic             in_overflow,
    input  logic             in_set_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_set_flags,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v,
    output logic             flags_wr
);

    localparam int ENT_W = WIDTH + 5;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             head_q, head_d;
    logic             tail_q, tail_d;
    logic [3:0]       nzcv_q, nzcv_d;
    logic             flags_wr_q, flags_wr_d;

    logic             push, pop, commit;
    logic [ENT_W-1:0] ent_in;
    logic [ENT_W-1:0] ent_all [2];
    logic [ENT_W-1:0] head_ent;
    logic [3:0]       head_nzcv;
    logic             head_set;
    logic [3:0]       flags_vis;

    // Handshake qualifiers come only from the registered occupancy state.
    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Entry layout: {sum, n, z, c, v, set_flags}
    assign ent_in = {in_sum, in_sum[WIDTH-1], (in_sum == '0), in_carry, in_overflow, in_set_flags};

    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
        localparam logic IDX = (gi == 1);
        logic [ENT_W-1:0] ent_q;

        always_ff @(posedge clk) begin
            if (push && (tail_q == IDX)) begin
                ent_q <= ent_in;
            end
        end

        assign ent_all[gi] = ent_q;
    end

    assign head_ent  = ent_all[head_q];
    assign head_nzcv = head_ent[4:1];
    assign head_set  = head_ent[0];
    assign commit    = pop & head_set;

    always_comb begin
        state_d    = state_q;
        head_d     = head_q ^ pop;
        tail_d     = tail_q ^ push;
        nzcv_d     = nzcv_q;
        flags_wr_d = 1'b0;

        case (state_q)
            EMPTY: if (push) state_d = ONE;
            ONE: begin
                if (push && !pop)      state_d = FULL;
                else if (pop && !push) state_d = EMPTY;
            end
            FULL:  if (pop) state_d = ONE;
            default: state_d = EMPTY;
        endcase

        if (commit) begin
            nzcv_d     = head_nzcv;
            flags_wr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= EMPTY;
            head_q     <= 1'b0;
            tail_q     <= 1'b0;
            nzcv_q     <= 4'b0000;
            flags_wr_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            nzcv_q     <= nzcv_d;
            flags_wr_q <= flags_wr_d;
        end
    end

    // Storage is never reset, so the head is masked while the buffer is empty.
    assign out_sum       = out_valid ? head_ent[ENT_W-1:5] : '0;
    assign out_set_flags = out_valid & head_set;
    assign flags_wr      = flags_wr_q;

`ifdef FLAGS_BYPASS_EN
    assign flags_vis = commit ? head_nzcv : nzcv_q;
`else
    assign flags_vis = nzcv_q;
`endif

    assign {flag_n, flag_z, flag_c, flag_v} = flags_vis;

endmodule

// File: tb/tb_adder_result_stage.sv
// Scoreboard bench for adder_result_stage: directed scenarios followed by randomized traffic.
module tb_adder_result_stage;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [63:0] in_sum = 64'd0;
    logic        in_carry = 1'b0;
    logic        in_overflow = 1'b0;
    logic        in_set_flags = 1'b0;
    logic        out_ready = 1'b0;
    logic        in_ready, out_valid, out_set_flags;
    logic [63:0] out_sum;
    logic        flag_n, flag_z, flag_c, flag_v, flags_wr;

    adder_result_stage #(.WIDTH(64)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sum       (in_sum),
        .in_carry     (in_carry),
        .in_overflow  (in_overflow),
        .in_set_flags (in_set_flags),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sum      (out_sum),
        .out_set_flags(out_set_flags),
        .flag_n       (flag_n),
        .flag_z       (flag_z),
        .flag_c       (flag_c),
        .flag_v       (flag_v),
        .flags_wr     (flags_wr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] sum;
        logic [3:0]  nzcv;
        logic        set;
    } ent_t;

    ent_t       sb[$];
    logic [3:0] nzcv_m = 4'b0000;
    logic       wr_m = 1'b0;
    logic       pop_pending = 1'b0;
    int         n_vec = 0;
    int         n_fail = 0;

    function automatic logic [3:0] flags_of(input logic [63:0] s, input logic c, input logic v);
        return {s[63], (s == 64'd0), c, v};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares the DUT against the scoreboard on every falling edge.
    always @(negedge clk) begin
        logic [3:0] f;
        if (!reset_n) begin
            pop_pending = 1'b0;
            chk("rst_out_valid", 64'(out_valid), 64'd0);
            chk("rst_in_ready", 64'(in_ready), 64'd1);
            chk("rst_out_sum", out_sum, 64'd0);
            chk("rst_nzcv", 64'({flag_n, flag_z, flag_c, flag_v}), 64'd0);
            chk("rst_flags_wr", 64'(flags_wr), 64'd0);
        end else begin
            chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
            chk("in_ready", 64'(in_ready), 64'(sb.size() != 2));
            if (sb.size() != 0) begin
                chk("out_sum", out_sum, sb[0].sum);
                chk("out_set_flags", 64'(out_set_flags), 64'(sb[0].set));
            end else begin
                chk("out_sum_empty", out_sum, 64'd0);
                chk("out_set_flags_empty", 64'(out_set_flags), 64'd0);
            end
            pop_pending = (sb.size() != 0) && out_ready;
            f = nzcv_m;
`ifdef FLAGS_BYPASS_EN
            if (pop_pending && sb[0].set) f = sb[0].nzcv;
`endif
            chk("nzcv", 64'({flag_n, flag_z, flag_c, flag_v}), 64'(f));
            chk("flags_wr", 64'(flags_wr), 64'(wr_m));
        end
    end

    // The model consumes the head on each accepted pop.
    always @(posedge clk) begin
        ent_t e;
        if (pop_pending) begin
            e = sb.pop_front();
            $display("pop sum=%h nzcv=%b set=%0d", e.sum, e.nzcv, e.set);
            if (e.set) begin
                nzcv_m = e.nzcv;
                wr_m   = 1'b1;
            end else begin
                wr_m = 1'b0;
            end
            pop_pending = 1'b0;
        end else begin
            wr_m = 1'b0;
        end
    end

    // This task is called at posedge+1. It pushes the expected entry if the input handshake occurs at the next edge.
    task automatic step();
        bit rdy;
        rdy = (sb.size() != 2);
        @(posedge clk);
        if (in_valid && rdy && reset_n)
            sb.push_back('{in_sum, flags_of(in_sum, in_carry, in_overflow), in_set_flags});
        #1;
    endtask

    task automatic drive(input bit v, input logic [63:0] s, input bit c, input bit o,
                         input bit st, input bit r);
        in_valid     = v;
        in_sum       = s;
        in_carry     = c;
        in_overflow  = o;
        in_set_flags = st;
        out_ready    = r;
        step();
    endtask

    task automatic mid_reset();
        #2;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("t1_out_valid", 64'(out_valid), 64'd0);
        chk("t1_in_ready", 64'(in_ready), 64'd1);
        chk("t1_nzcv", 64'({flag_n, flag_z, flag_c, flag_v}), 64'd0);
        chk("t1_flags_wr", 64'(flags_wr), 64'd0);
        sb.delete();
        nzcv_m = 4'b0000;
        wr_m   = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        logic [63:0] s;
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Single pass with a zero sum and carry set.
        drive(1, 64'd0, 1, 0, 1, 1);
        drive(0, 64'd0, 0, 0, 0, 1);
        chk("t2_nzcv", 64'({flag_n, flag_z, flag_c, flag_v}), 64'(4'b0110));
        chk("t2_flags_wr", 64'(flags_wr), 64'd1);
        drive(0, 64'd0, 0, 0, 0, 1);
        chk("t2_flags_wr_pulse", 64'(flags_wr), 64'd0);

        // Backpressure: the third input is ignored while the buffer is full.
        drive(1, 64'd1, 0, 0, 0, 0);
        drive(1, 64'h8000_0000_0000_0000, 0, 0, 0, 0);
        chk("t3_in_ready_full", 64'(in_ready), 64'd0);
        drive(1, 64'hDEAD_BEEF_0000_0003, 0, 0, 0, 0);
        drive(0, 64'd0, 0, 0, 0, 1);
        drive(0, 64'd0, 0, 0, 0, 1);
        drive(0, 64'd0, 0, 0, 0, 0);

        // A pop with set_flags clear leaves NZCV untouched.
        drive(1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 1);
        drive(0, 64'd0, 0, 0, 0, 1);
        chk("t4_nzcv", 64'({flag_n, flag_z, flag_c, flag_v}), 64'(4'b0110));
        chk("t4_flags_wr", 64'(flags_wr), 64'd0);

        // Simultaneous push and pop while the buffer holds one entry.
        drive(1, 64'd1, 0, 0, 0, 0);
        for (int k = 2; k <= 10; k++) drive(1, 64'(k), 0, 0, 0, 1);
        drive(0, 64'd0, 0, 0, 0, 1);
        drive(0, 64'd0, 0, 0, 0, 0);

        // Flag visibility during the pop cycle.
        drive(1, 64'h8000_0000_0000_0000, 0, 1, 1, 0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #2;
`ifdef FLAGS_BYPASS_EN
        chk("t6_flag_n_pop_cycle", 64'(flag_n), 64'd1);
        chk("t6_flag_v_pop_cycle", 64'(flag_v), 64'd1);
`else
        chk("t6_flag_n_pop_cycle", 64'(flag_n), 64'd0);
        chk("t6_flag_v_pop_cycle", 64'(flag_v), 64'd0);
`endif
        step();
        chk("t6_nzcv_after", 64'({flag_n, flag_z, flag_c, flag_v}), 64'(4'b1001));

        // Reset while the buffer holds two entries.
        drive(1, 64'd5, 0, 0, 1, 0);
        drive(1, 64'd6, 1, 1, 1, 0);
        mid_reset();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 3))
                0:       s = 64'd0;
                1:       s = {$urandom, $urandom};
                2:       s = 64'h8000_0000_0000_0000 | 64'($urandom_range(0, 255));
                default: s = 64'hFFFF_FFFF_FFFF_FFFF;
            endcase
            drive($urandom_range(0, 3) != 0, s, 1'($urandom), 1'($urandom),
                  1'($urandom), $urandom_range(0, 2) != 0);
            if (i % 997 == 996) mid_reset();
        end
        for (int i = 0; i < 3; i++) drive(0, 64'd0, 0, 0, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
